// File: rtl/fan_ramp_scheduler_if.sv
// Button-pulse inputs and fan command outputs of the ramp scheduler.
// ramp_state mirrors the ramp FSM state for observation.
interface fan_ramp_scheduler_if #(
    parameter int N = 12
);
    logic         speed_p;
    logic         timer_p;
    logic [N-1:0] duty;
    logic [2:0]   level;
    logic [2:0]   timer_led;
    logic         busy;
    logic [1:0]   ramp_state;

    // Pulses are single-cycle strobes sampled on posedge clk; outputs are registered state.
    modport master (
        output speed_p, timer_p,
        input  duty, level, timer_led, busy, ramp_state
    );
    modport slave (
        input  speed_p, timer_p,
        output duty, level, timer_led, busy, ramp_state
    );
endinterface

// File: rtl/fan_ramp_scheduler.sv
// Fan speed level selector with rate-limited duty ramp and auto-off timer.
// Duty moves toward the level's target by at most RAMP_STEP per 1 ms tick.
module fan_ramp_scheduler #(
    parameter int SYS_FREQ         = 125,
    parameter int N                = 12,
    parameter int TICK_CYCLES      = SYS_FREQ * 1000,
    parameter int RAMP_STEP        = 64,
    parameter int TIMER_UNIT_TICKS = 60000
) (
    input  logic                 clk,
    input  logic                 reset_p,
    fan_ramp_scheduler_if.slave  bus
);
    localparam int TICK_W  = $clog2(TICK_CYCLES + 1);
    localparam int REM_MAX = 5 * TIMER_UNIT_TICKS;
    localparam int REM_W   = $clog2(REM_MAX + 1);

    typedef enum logic [1:0] {R_HOLD, R_UP, R_DOWN} ramp_state_t;
    typedef enum logic [1:0] {T_OFF, T_1, T_3, T_5} timer_mode_t;

    logic [TICK_W-1:0] r_tick_cnt;
    logic [2:0]        r_level;
    logic [N-1:0]      r_duty;
    ramp_state_t       r_state;
    timer_mode_t       r_mode;
    logic [REM_W-1:0]  r_remain;

    logic              w_tick;
    logic              w_expire;
    logic [N-1:0]      w_target;
    logic [N:0]        w_sum;
    logic [N-1:0]      w_up;
    logic [N-1:0]      w_gap;
    logic [N-1:0]      w_dn;
    ramp_state_t       w_state_nxt;
    logic [N-1:0]      w_duty_nxt;
    timer_mode_t       w_mode_nxt;
    logic [REM_W-1:0]  w_remain_nxt;
    logic [2:0]        w_level_nxt;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)     r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // N-bit wrap makes level 7 land exactly on full scale: 8<<(N-3) wraps to 0, minus 1.
    assign w_target = (r_level == 3'd0) ? '0
                    : ((N'(r_level) + N'(1)) << (N - 3)) - N'(1);

    assign w_sum = {1'b0, r_duty} + (N+1)'(RAMP_STEP);
    assign w_up  = (w_sum > {1'b0, w_target}) ? w_target : w_sum[N-1:0];
    assign w_gap = r_duty - w_target;
    assign w_dn  = (w_gap <= N'(RAMP_STEP)) ? w_target : r_duty - N'(RAMP_STEP);

    always_comb begin
        w_state_nxt = R_HOLD;
        w_duty_nxt  = r_duty;
        if (r_duty < w_target)      w_state_nxt = R_UP;
        else if (r_duty > w_target) w_state_nxt = R_DOWN;
        // The registered state lags a retarget by a cycle, so direction is re-checked here.
        if (w_tick) begin
            case (r_state)
                R_UP:    if (r_duty < w_target) w_duty_nxt = w_up;
                R_DOWN:  if (r_duty > w_target) w_duty_nxt = w_dn;
                default: w_duty_nxt = r_duty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state <= R_HOLD;
            r_duty  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    assign w_expire = (r_mode != T_OFF) && (r_level != 3'd0) && (r_remain == '0);

    always_comb begin
        w_level_nxt  = r_level;
        w_mode_nxt   = r_mode;
        w_remain_nxt = r_remain;
        if (w_expire) begin
            w_level_nxt  = 3'd0;
            w_mode_nxt   = T_OFF;
            w_remain_nxt = '0;
        end else begin
            if (bus.speed_p) w_level_nxt = r_level + 3'd1;
            if (bus.speed_p && r_level == 3'd7) begin
                w_mode_nxt   = T_OFF;
                w_remain_nxt = '0;
            end else if (bus.timer_p && r_level != 3'd0) begin
                case (r_mode)
                    T_OFF: begin w_mode_nxt = T_1;   w_remain_nxt = REM_W'(TIMER_UNIT_TICKS);     end
                    T_1:   begin w_mode_nxt = T_3;   w_remain_nxt = REM_W'(3 * TIMER_UNIT_TICKS); end
                    T_3:   begin w_mode_nxt = T_5;   w_remain_nxt = REM_W'(5 * TIMER_UNIT_TICKS); end
                    default: begin w_mode_nxt = T_OFF; w_remain_nxt = '0; end
                endcase
            end else if (w_tick && r_mode != T_OFF && r_level != 3'd0) begin
                w_remain_nxt = r_remain - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_level  <= 3'd0;
            r_mode   <= T_OFF;
            r_remain <= '0;
        end else begin
            r_level  <= w_level_nxt;
            r_mode   <= w_mode_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    assign bus.duty       = r_duty;
    assign bus.level      = r_level;
    assign bus.busy       = (r_state != R_HOLD);
    assign bus.ramp_state = r_state;
    assign bus.timer_led  = (r_mode == T_1) ? 3'b001 :
                            (r_mode == T_3) ? 3'b010 :
                            (r_mode == T_5) ? 3'b100 : 3'b000;
endmodule
